// File: rtl/fb_sram_writer.sv
// Frame-buffer writer: packs 24-bit RGB pixels into a 16-bit async SRAM as a
// contiguous byte stream (R0 G0 B0 R1 ...), even byte in [15:8].
module fb_sram_writer #(
    parameter int unsigned NUM_PIX   = 307200,
    parameter logic [19:0] BASE_ADDR = 20'h0,
    parameter int unsigned WE_LOW    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_rgb,
    output logic        frame_done,
    output logic [19:0] sram_addr,
    inout  wire  [15:0] sram_io,
    output logic        sram_ce_b,
    output logic        sram_we_b,
    output logic        sram_oe_b,
    output logic        sram_ub_b,
    output logic        sram_lb_b
);

    localparam int CW = $clog2(NUM_PIX + 1);

    typedef enum logic [2:0] {IDLE, ACCEPT, SETUP, PULSE, HOLD, FLUSH} state_t;

    state_t        state_q, state_d;
    logic [19:0]   ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    left_q, left_d;
    logic          lv_q, lv_d;
    logic [15:0]   w0_q, w0_d, w1_q, w1_d;
    logic          more_q, more_d;
    logic          flush_q, flush_d;
    logic [2:0]    pc_q, pc_d;
    logic          done_q, done_d;
    logic          drive;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            left_q  <= '0;
            lv_q    <= 1'b0;
            w0_q    <= '0;
            w1_q    <= '0;
            more_q  <= 1'b0;
            flush_q <= 1'b0;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            lv_q    <= lv_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            more_q  <= more_d;
            flush_q <= flush_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        lv_d    = lv_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        more_d  = more_q;
        flush_d = flush_q;
        pc_d    = pc_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = ACCEPT;
                    ptr_d   = BASE_ADDR;
                    cnt_d   = '0;
                    lv_d    = 1'b0;
                    flush_d = 1'b0;
                end
            end
            ACCEPT: begin
                if (pix_valid) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = SETUP;
                    if (!lv_q) begin
                        // Even pixel: {R,G} now, B waits for the next pixel's R.
                        w0_d   = pix_rgb[23:8];
                        left_d = pix_rgb[7:0];
                        lv_d   = 1'b1;
                        more_d = 1'b0;
                    end else begin
                        w0_d   = {left_q, pix_rgb[23:16]};
                        w1_d   = pix_rgb[15:0];
                        lv_d   = 1'b0;
                        more_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = PULSE;
                pc_d    = '0;
            end
            PULSE: begin
                pc_d = pc_q + 3'd1;
                if (pc_q == 3'(WE_LOW - 1)) state_d = HOLD;
            end
            HOLD: begin
                ptr_d = ptr_q + 20'd1;
                if (more_q) begin
                    w0_d    = w1_q;
                    more_d  = 1'b0;
                    state_d = SETUP;
                end else if (cnt_q < CW'(NUM_PIX)) begin
                    state_d = ACCEPT;
                end else if (lv_q) begin
                    state_d = FLUSH;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                // Odd-length frame: last B goes to the upper byte only.
                w0_d    = {left_q, 8'h00};
                lv_d    = 1'b0;
                flush_d = 1'b1;
                state_d = SETUP;
            end
            default: state_d = IDLE;
        endcase
    end

    assign drive      = (state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD);
    assign pix_ready  = (state_q == ACCEPT);
    assign frame_done = done_q;
    assign sram_addr  = ptr_q;
    assign sram_io    = drive ? w0_q : 16'hzzzz;
    assign sram_ce_b  = !drive;
    assign sram_we_b  = (state_q != PULSE);
    assign sram_oe_b  = 1'b1;
    assign sram_ub_b  = !drive;
    assign sram_lb_b  = !drive || flush_q;

endmodule
